// File: rtl/y86_mem_pkg.sv
// Shared types and constants for the Y86 data memory.
package y86_mem_pkg;

   localparam int unsigned DMEM_DEPTH_BYTES = 1024;
   localparam int unsigned LANES            = 4;

   typedef logic [1:0] lane_t;

   typedef enum logic [0:0] {
      MS_CLEAR,
      MS_READY
   } mem_state_e;

endpackage

// File: rtl/dmem_bank.sv
// One byte-wide storage bank: synchronous write port, asynchronous read port.
module dmem_bank #(
   parameter int unsigned ROWS = 256
) (
   input  logic                    clk_i,
   input  logic                    we_i,
   input  logic [$clog2(ROWS)-1:0] waddr_i,
   input  logic [7:0]              wdata_i,
   input  logic [$clog2(ROWS)-1:0] raddr_i,
   output logic [7:0]              rdata_o
);

   logic [7:0] mem_q [ROWS];

   // Commit one byte per edge when enabled; storage has no reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/y86_dmem.sv
// Y86 data memory: byte-addressed, little-endian, unaligned-capable 32-bit accesses
// with a sticky fault register. Define Y86_DMEM_CLEAR_EN to zero the storage after
// reset before ready_o rises; otherwise ready_o rises one edge after reset release.
module y86_dmem
   import y86_mem_pkg::*;
#(
   parameter int unsigned DEPTH_BYTES = DMEM_DEPTH_BYTES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_data_o,
   output logic        ready_o,
   output logic        mem_err_o,
   output logic [31:0] err_addr_o
);

   localparam int unsigned ROWS = DEPTH_BYTES / LANES;
   localparam int unsigned RW   = $clog2(ROWS);

   typedef logic [RW-1:0] row_t;

   mem_state_e  state_q;
   row_t        clr_row_q;
   logic        ready_q;
   logic        err_q;
   logic [31:0] err_addr_q;

   logic        in_range;
   logic        rd_ok;
   logic        wr_ok;
   logic        fault;
   logic        clearing;
   logic [31:0] rd_word;
   row_t        acc_row    [LANES];
   logic [7:0]  acc_wdata  [LANES];
   logic [7:0]  bank_rdata [LANES];

   // 33-bit sum so addresses near 2^32 cannot wrap into range.
   assign in_range = ({1'b0, mem_addr_i} + 33'd3) < 33'(DEPTH_BYTES);
   assign rd_ok    = ready_q & mem_read_i & ~mem_write_i & in_range;
   assign wr_ok    = ready_q & mem_write_i & ~mem_read_i & in_range;
   assign fault    = ready_q & (mem_read_i | mem_write_i)
                   & ((mem_read_i & mem_write_i) | ~in_range);
   assign clearing = (state_q == MS_CLEAR);

   // Per-bank row and byte steering: bank k holds access byte (k - a[1:0]) mod 4.
   always_comb begin
      lane_t       off;
      logic [31:0] byte_addr;
      off       = '0;
      byte_addr = '0;
      rd_word   = '0;
      for (int k = 0; k < LANES; k++) begin
         off                = lane_t'(k) - mem_addr_i[1:0];
         byte_addr          = mem_addr_i + 32'(off);
         acc_row[k]         = byte_addr[RW+1:2];
         acc_wdata[k]       = mem_data_i[8*off +: 8];
         rd_word[8*off +: 8] = bank_rdata[k];
      end
   end

   assign mem_data_o = rd_ok ? rd_word : '0;

   for (genvar k = 0; k < LANES; k++) begin : g_bank
      dmem_bank #(
         .ROWS (ROWS)
      ) u_bank (
         .clk_i   (clk),
         .we_i    (clearing | wr_ok),
         .waddr_i (clearing ? clr_row_q : acc_row[k]),
         .wdata_i (clearing ? 8'h00 : acc_wdata[k]),
         .raddr_i (acc_row[k]),
         .rdata_o (bank_rdata[k])
      );
   end

   // Start-up FSM: optional zero sweep, then ready until the next reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
`ifdef Y86_DMEM_CLEAR_EN
         state_q   <= MS_CLEAR;
`else
         state_q   <= MS_READY;
`endif
         clr_row_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         unique case (state_q)
            MS_CLEAR: begin
               if (clr_row_q == row_t'(ROWS - 1)) begin
                  state_q <= MS_READY;
                  ready_q <= 1'b1;
               end else begin
                  clr_row_q <= clr_row_q + row_t'(1);
               end
            end
            MS_READY: ready_q <= 1'b1;
         endcase
      end
   end

   // Sticky fault flag; the address is kept from the first fault only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else if (fault) begin
         err_q <= 1'b1;
         if (!err_q) begin
            err_addr_q <= mem_addr_i;
         end
      end
   end

   assign ready_o    = ready_q;
   assign mem_err_o  = err_q;
   assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_y86_dmem.sv
// Randomized self-checking bench for y86_dmem against a byte-array reference model.
module tb_y86_dmem;

   localparam int unsigned DEPTH = 1024;
`ifdef Y86_DMEM_CLEAR_EN
   localparam int CLR_EDGES = DEPTH / 4;
`else
   localparam int CLR_EDGES = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_read_i = 1'b0;
   logic        mem_write_i = 1'b0;
   logic [31:0] mem_addr_i = '0;
   logic [31:0] mem_data_i = '0;
   logic [31:0] mem_data_o;
   logic        ready_o;
   logic        mem_err_o;
   logic [31:0] err_addr_o;

   always #5 clk = ~clk;

   y86_dmem #(
      .DEPTH_BYTES (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_read_i  (mem_read_i),
      .mem_write_i (mem_write_i),
      .mem_addr_i  (mem_addr_i),
      .mem_data_i  (mem_data_i),
      .mem_data_o  (mem_data_o),
      .ready_o     (ready_o),
      .mem_err_o   (mem_err_o),
      .err_addr_o  (err_addr_o)
   );

   // Reference model: plain byte array plus fault bookkeeping.
   logic [7:0]  mem_m [DEPTH];
   bit          ready_m;
   bit          err_m;
   logic [31:0] err_addr_m;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] obs;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: observed %h, expected %h at %0t", tag, got, exp, $time);
   endtask

   task automatic idle();
      mem_read_i  = 1'b0;
      mem_write_i = 1'b0;
      mem_addr_i  = '0;
      mem_data_i  = '0;
   endtask

   // One request cycle; starts just after a rising edge and ends just after the next.
   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] got);
      logic [32:0] last;
      bit          in_rng;
      bit          flt;
      logic [31:0] exp_rd;
      last   = {1'b0, a} + 33'd3;
      in_rng = (last < 33'(DEPTH));
      exp_rd = '0;
      if (ready_m && rd && !wr && in_rng)
         for (int k = 0; k < 4; k++) exp_rd[8*k +: 8] = mem_m[int'(a) + k];
      mem_read_i  = rd;
      mem_write_i = wr;
      mem_addr_i  = a;
      mem_data_i  = d;
      #4;
      got = mem_data_o;
      chk("rdata", got, exp_rd);
      @(posedge clk);
      flt = ready_m && (rd || wr) && ((rd && wr) || !in_rng);
      if (ready_m && wr && !rd && in_rng)
         for (int k = 0; k < 4; k++) mem_m[int'(a) + k] = d[8*k +: 8];
      if (flt && !err_m) begin
         err_m      = 1'b1;
         err_addr_m = a;
      end
      #1;
      idle();
      chk("mem_err", mem_err_o, err_m);
      chk("err_addr", err_addr_o, err_addr_m);
   endtask

   task automatic start_reset();
      rst         = 1'b0;
      mem_read_i  = 1'b1;
      mem_write_i = 1'b0;
      mem_addr_i  = 32'h10;
      mem_data_i  = '0;
      #1;
      chk("rst_ready", ready_o, 0);
      chk("rst_err", mem_err_o, 0);
      chk("rst_err_addr", err_addr_o, 0);
      chk("rst_rdata", mem_data_o, 0);
      ready_m    = 1'b0;
      err_m      = 1'b0;
      err_addr_m = '0;
      repeat (2) @(posedge clk);
   endtask

   // Release reset and count edges until ready; a conflicting request is held
   // throughout and must be ignored. abort_at re-asserts reset after that edge.
   task automatic release_and_wait(input int abort_at);
      logic [31:0] dummy;
      @(negedge clk);
      rst         = 1'b1;
      mem_read_i  = 1'b1;
      mem_write_i = 1'b1;
      mem_addr_i  = 32'h20;
      mem_data_i  = 32'hDEAD_BEEF;
      for (int i = 1; i <= CLR_EDGES; i++) begin
         chk("clr_rdata", mem_data_o, 0);
         @(posedge clk);
         #1;
         if (i == abort_at) begin
            rst = 1'b0;
            #1;
            chk("abort_ready", ready_o, 0);
            idle();
            return;
         end
         chk("clr_ready", ready_o, (i == CLR_EDGES));
         chk("clr_err", mem_err_o, 0);
      end
      idle();
      ready_m = 1'b1;
`ifdef Y86_DMEM_CLEAR_EN
      foreach (mem_m[j]) mem_m[j] = 8'h00;
`else
      for (int r = 0; r < int'(DEPTH) / 4; r++) access(1'b0, 1'b1, 32'(4 * r), '0, dummy);
`endif
   endtask

   task automatic random_phase(input int n);
      int          sel;
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         sel = $urandom_range(0, 19);
         a   = 32'($urandom_range(0, DEPTH - 1));
         if (sel < 8)       access(1'b1, 1'b0, a, $urandom, obs);
         else if (sel < 15) access(1'b0, 1'b1, a, $urandom, obs);
         else if (sel < 16) access(1'b1, 1'b1, a, $urandom, obs);
         else if (sel < 17) access(1'b0, 1'b0, a, $urandom, obs);
         else if (sel < 19)
            access(sel[0], ~sel[0], 32'(DEPTH - 4 + $urandom_range(0, 3)), $urandom, obs);
         else               access(1'b1, 1'b0, $urandom, '0, obs);
      end
   endtask

   initial begin
      #2;
      start_reset();
      release_and_wait(0);

      access(1'b1, 1'b0, 32'h10, '0, obs);
      chk("tp_rd_10", obs, 32'h0000_0000);

      access(1'b0, 1'b1, 32'h100, 32'h1122_3344, obs);
      access(1'b1, 1'b0, 32'h100, '0, obs);
      chk("tp_rd_100", obs, 32'h1122_3344);
      access(1'b1, 1'b0, 32'h101, '0, obs);
      chk("tp_rd_101", obs, 32'h0011_2233);

      access(1'b0, 1'b1, 32'h1FE, 32'hAABB_CCDD, obs);
      access(1'b1, 1'b0, 32'h1FC, '0, obs);
      chk("tp_rd_1fc", obs, 32'hCCDD_0000);
      access(1'b1, 1'b0, 32'h200, '0, obs);
      chk("tp_rd_200", obs, 32'h0000_AABB);

      access(1'b0, 1'b1, 32'h3FE, 32'h5566_7788, obs);
      chk("tp_oor_err", mem_err_o, 1);
      chk("tp_oor_addr", err_addr_o, 32'h3FE);
      access(1'b1, 1'b0, 32'h500, '0, obs);
      chk("tp_2nd_addr", err_addr_o, 32'h3FE);
      access(1'b1, 1'b0, 32'h3FC, '0, obs);
      chk("tp_rd_3fc", obs, 32'h0000_0000);

      random_phase(400);

      // Reset part-way through the sweep, then a full clean start.
      start_reset();
      release_and_wait(100);
      start_reset();
      release_and_wait(0);

      access(1'b1, 1'b0, 32'h100, '0, obs);
      chk("tp_post_rst_100", obs, 32'h0000_0000);
      access(1'b1, 1'b0, 32'h20, '0, obs);
      chk("tp_post_rst_20", obs, 32'h0000_0000);

      access(1'b1, 1'b1, 32'h40, 32'hFFFF_FFFF, obs);
      chk("tp_both_rdata", obs, 32'h0000_0000);
      chk("tp_both_err", mem_err_o, 1);
      chk("tp_both_addr", err_addr_o, 32'h40);
      access(1'b1, 1'b0, 32'h40, '0, obs);
      chk("tp_rd_40", obs, 32'h0000_0000);

      random_phase(300);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/y86_dmem.md
# y86_dmem

Data-memory responder on the far end of the Y86 core's data port. It answers the core's `mem_read`/`mem_write`/`mem_addr`/`mem_data` requests with byte-addressed, little-endian, unaligned-capable 32-bit accesses. After reset it sweeps its storage to zero and only then raises `ready_o`. Out-of-range and conflicting accesses are latched as a sticky fault, together with the faulting address, for the core's status logic.

## Interface
Parameters:
- `DEPTH_BYTES`, 1024: storage size in bytes; power of two, ≥ 16.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_read_i`  in  1  read request, level, this cycle.
- `mem_write_i`  in  1  write request, level, this cycle.
- `mem_addr_i`  in  32  byte address of the 4-byte access.
- `mem_data_i`  in  32  write data.
- `mem_data_o`  out  32  read data, combinational from the current array contents.
- `ready_o`  out  1  storage valid; requests are honoured only while high.
- `mem_err_o`  out  1  sticky fault flag.
- `err_addr_o`  out  32  address of the first fault since reset.

## Operation
- Storage: 4 byte-wide banks of `DEPTH_BYTES/4` rows each. Byte `b` is held in bank `b[1:0]`, row `b>>2`.
- Access at address `a` covers bytes `a..a+3`. Byte `a+k` maps to data bits `[8k+7:8k]`.
- Unaligned accesses split across two rows. Each bank computes its own row: `row_k = (a + ((k - a[1:0]) mod 4)) >> 2`.
- A request is legal when `ready_o=1`, exactly one of read/write is set, and `a + 3 < DEPTH_BYTES`. The `a + 3` sum is computed 33 bits wide, so no wrap-around occurs.
- Legal write: all 4 bytes commit at the next rising edge.
- Legal read: `mem_data_o` returns the assembled bytes. In every other case `mem_data_o` = 0.
- Faults:
  - read/write out of range, or read and write both high, while `ready_o=1`.
  - A faulting write stores nothing.
  - The cycle after the fault, `mem_err_o` goes to 1 and stays there until reset.
  - `err_addr_o` captures `mem_addr_i` only on the first fault.
- Requests while `ready_o=0` are ignored: no write, no fault, `mem_data_o`=0.
- FSM states:
  - MS_CLEAR: row counter `clr_row` runs 0 up to `DEPTH_BYTES/4-1` and writes zero to all 4 banks at that row. When it reaches the last row it moves to MS_READY.
  - MS_READY: terminal state. Only reset leaves it.

## Timing
- Reset values: state MS_CLEAR, `clr_row`=0, `ready_o`=0, `mem_err_o`=0, `err_addr_o`=0, `mem_data_o`=0.
- Clear takes exactly `DEPTH_BYTES/4` rising edges after `rst` deasserts. `ready_o` rises after the last clear edge; with 1024 bytes that is the 256th edge.
- Write latency is 1: a read in the cycle after a write returns the new data. Read latency is 0 (combinational).
- Reset asserted mid-clear or mid-operation takes effect immediately and asynchronously. On release the sweep restarts at row 0.
- Fault flag latency is 1 cycle.

## Configuration
- `Y86_DMEM_CLEAR_EN` defined:
  - The MS_CLEAR sweep runs as described above.
- `Y86_DMEM_CLEAR_EN` undefined:
  - The FSM resets directly into MS_READY and `ready_o` still resets to 0.
  - `ready_o` goes to 1 on the first rising edge after reset release.
  - Array contents are undefined until written; X in simulation.

## Structure
- Package `y86_mem_pkg` holds:
  - the default `DEPTH_BYTES`;
  - the state enum `{MS_CLEAR, MS_READY}`;
  - the byte-lane index type (2 bits);
  - the constant `LANES`=4.
- Sub-module `dmem_bank`, instantiated 4 times: one byte-wide bank with one synchronous write port and one asynchronous read port.
- The top level holds the FSM, row/lane address generation, byte steering, and the fault registers.

## Test plan
- Reset release with clear enabled, `DEPTH_BYTES`=1024 -> `ready_o` stays 0 for 256 edges and is 1 after the 256th; read at 0x10 -> 0x00000000.
- Write 0x11223344 to 0x100, then in the next cycle read 0x100 -> 0x11223344; read 0x101 -> 0x00112233.
- Write 0xAABBCCDD to 0x1FE (row-crossing) -> read 0x1FC returns 0xCCDD0000; read 0x200 returns 0x0000AABB.
- Write to 0x3FE (out of range) -> 0x3FE..0x3FF unchanged, `mem_err_o`=1 the next cycle, `err_addr_o`=0x3FE. A later fault at 0x500 leaves `err_addr_o`=0x3FE. A read at 0x3FC gives no new fault.
- Read and write both high at 0x40 with data 0xFFFFFFFF -> `mem_data_o`=0, 0x40 unchanged, `mem_err_o`=1.
- Assert `rst` at clear edge 100, release it two cycles later -> `ready_o` goes to 0 and then rises after 256 more edges. A request issued during the clear has no effect.
